// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state encoding
// and the default operand width used by both controller and datapath.
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier controller: cleared at operand load,
// advanced once per shift, flags the final iteration before it is counted.
module mult_iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] Count,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;
  assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/mult_control.sv
// Sequencing FSM for the shift-and-add multiplier: loads operands, runs WIDTH
// test/add/shift iterations, then pulses Done. All outputs are Moore outputs.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Q0,
  output logic             Load,
  output logic             Add,
  output logic             Shift,
  output logic             Done,
  output logic             Busy,
  output logic [CNT_W-1:0] Count
);

  mult_state_t state_q;
  mult_state_t state_d;
  logic        last;

  mult_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .Clk  (Clk),
    .Reset(Reset),
    .clear(Load),
    .inc  (Shift),
    .Count(Count),
    .last (last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start is only looked at in IDLE, so requests during Busy (including DONE) drop.
  always_comb begin
    state_d = state_q;
    Load    = 1'b0;
    Add     = 1'b0;
    Shift   = 1'b0;
    Done    = 1'b0;
    Busy    = 1'b1;
    unique case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_d = LOAD;
      end
      LOAD: begin
        Load    = 1'b1;
        state_d = TEST;
      end
      TEST: begin
        state_d = Q0 ? ADD : SHIFT;
      end
      ADD: begin
        Add     = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift   = 1'b1;
        state_d = last ? DONE : TEST;
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        Busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Randomised self-checking bench for mult_control: a cycle-queue model built
// from the multiplier bits predicts every output on every cycle.
module tb_mult_control;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          Clk   = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic          Q0    = 1'b0;
  logic          Load, Add, Shift, Done, Busy;
  logic [CW-1:0] Count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mult_control #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Start(Start),
    .Q0   (Q0),
    .Load (Load),
    .Add  (Add),
    .Shift(Shift),
    .Done (Done),
    .Busy (Busy),
    .Count(Count)
  );

  // One entry per expected cycle; q0 is the value the bench drives on Q0 then.
  typedef struct packed {
    logic          ld;
    logic          ad;
    logic          sh;
    logic          dn;
    logic          bz;
    logic [CW-1:0] cnt;
    logic          q0;
  } ent_t;

  ent_t          q[$];
  ent_t          exp_e;
  logic [CW-1:0] held   = '0;
  logic          chk_en = 1'b0;
  logic [W-1:0]  mplier = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic ent_t mk(input logic ld, ad, sh, dn, bz, input logic [CW-1:0] cnt,
                              input logic q0v);
    ent_t e;
    e.ld = ld; e.ad = ad; e.sh = sh; e.dn = dn; e.bz = bz; e.cnt = cnt; e.q0 = q0v;
    return e;
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic ent_t idle_ent();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, held, rnd());
  endfunction

  // Expected cycle sequence of one full multiply for multiplier m.
  task automatic push_op(input logic [W-1:0] m);
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, held, rnd()));
    for (int i = 0; i < W; i++) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, CW'(i), m[i]));
      if (m[i]) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, CW'(i), rnd()));
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, CW'(i), rnd()));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CW'(W), rnd()));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, return at next negedge.
  task automatic cyc(input logic st, input logic rs);
    Start = st;
    Reset = rs;
    Q0    = exp_e.q0;
    @(posedge Clk);
    if (rs) begin
      q.delete();
      held = '0;
    end else if (q.size() != 0) begin
      if (q[0].dn) held = q[0].cnt;
      void'(q.pop_front());
    end else if (st) begin
      push_op(mplier);
    end
    exp_e = (q.size() != 0) ? q[0] : idle_ent();
    @(negedge Clk);
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("Load", 32'(Load), 32'(exp_e.ld));
      chk("Add", 32'(Add), 32'(exp_e.ad));
      chk("Shift", 32'(Shift), 32'(exp_e.sh));
      chk("Done", 32'(Done), 32'(exp_e.dn));
      chk("Busy", 32'(Busy), 32'(exp_e.bz));
      chk("Count", 32'(Count), 32'(exp_e.cnt));
      chk("strobe_onehot", 32'($countones({Load, Add, Shift, Done}) <= 1), 32'd1);
    end
  end

  // Start one multiply from IDLE, measure Done cycle and Add pulses, end in the IDLE cycle.
  task automatic run_op(input logic [W-1:0] m, input int exp_done, input int exp_adds,
                        input bit noise);
    int adds = 0;
    int dk   = -1;
    mplier = m;
    cyc(1'b1, 1'b0);
    chk("load_at_cycle1", 32'(Load), 32'd1);
    for (int k = 1; k <= 60; k++) begin
      if (Add) adds++;
      if (Done) begin
        dk = k;
        break;
      end
      cyc(noise ? rnd() : 1'b0, 1'b0);
    end
    chk("done_cycle", 32'(dk), 32'(exp_done));
    chk("add_pulses", 32'(adds), 32'(exp_adds));
    cyc(noise, 1'b0);
    if (noise) chk("start_at_done_ignored", 32'(Load | Busy), 32'd0);
  endtask

  initial begin
    int dones;
    int d_at;
    int l_at;
    logic [W-1:0] m;

    exp_e = idle_ent();
    @(negedge Clk);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk_en = 1'b1;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_count", 32'(Count), 32'd0);
    chk("reset_strobes", 32'({Load, Add, Shift, Done}), 32'd0);

    run_op(8'h00, 18, 0, 1'b0);
    chk("count_after_exit", 32'(Count), 32'd0);
    run_op(8'hFF, 26, 8, 1'b0);
    run_op(8'h0B, 21, 3, 1'b0);

    // Abort during iteration 4 (its TEST is cycle 10 for a zero multiplier).
    mplier = 8'h00;
    cyc(1'b1, 1'b0);
    repeat (9) cyc(1'b0, 1'b0);
    chk("iter4_count", 32'(Count), 32'd4);
    cyc(1'b0, 1'b1);
    chk("abort_idle_busy", 32'(Busy), 32'd0);
    chk("abort_idle_count", 32'(Count), 32'd0);
    dones = 0;
    repeat (25) begin
      if (Done) dones++;
      cyc(1'b0, 1'b0);
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op(8'h0B, 21, 3, 1'b0);

    // Start noise during Busy and on the DONE cycle.
    m = W'($urandom);
    run_op(m, 2 + 2 * W + $countones(m), $countones(m), 1'b1);

    // Start held high: next LOAD two cycles after Done.
    mplier = W'($urandom);
    d_at = -1;
    l_at = -1;
    for (int t = 1; t <= 80; t++) begin
      cyc(1'b1, 1'b0);
      if (Done && d_at < 0) d_at = t;
      if (Load && d_at >= 0) begin
        l_at = t;
        break;
      end
    end
    chk("held_start_gap", 32'(l_at - d_at), 32'd2);
    repeat (40) cyc(1'b0, 1'b0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      mplier = W'($urandom);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 96) == 0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
